// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request and result handshake.
// Define ALU_MUL_EN to build in the multi-cycle shift-add multiplier (OP=8).
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             ck,
  input  logic             res_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] L,
  input  logic [WIDTH-1:0] R,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic [3:0]       flags,
  output logic             err
);
  // state | meaning
  // IDLE  | waiting for a request
  // BUSY  | shift-add multiply in progress (only reachable with ALU_MUL_EN)
  // DONE  | result held on O/flags/err until out_ready
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_LOADI = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;

  state_t           state;
  logic [WIDTH-1:0] o_q;
  logic [3:0]       flags_q;
  logic             err_q;
  logic             accept;

  logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] res_c;
  logic             c_c, v_c, err_c;
  logic [3:0]       flags_c;

  assign amt    = R[SHW-1:0];
  assign sum_w  = {1'b0, L} + {1'b0, R};
  assign diff_w = {1'b0, L} - {1'b0, R};
  // Extra bit on the shifted-out side captures the last bit lost; zero for amount 0.
  assign shl_w  = {1'b0, L} << amt;
  assign shr_w  = {L, 1'b0} >> amt;

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    err_c = 1'b0;
    case (OP)
      OP_ADD: begin
        res_c = sum_w[WIDTH-1:0];
        c_c   = sum_w[WIDTH];
        v_c   = (L[WIDTH-1] == R[WIDTH-1]) && (sum_w[WIDTH-1] != L[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff_w[WIDTH-1:0];
        c_c   = diff_w[WIDTH];
        v_c   = (L[WIDTH-1] != R[WIDTH-1]) && (diff_w[WIDTH-1] != L[WIDTH-1]);
      end
      OP_AND:   res_c = L & R;
      OP_OR:    res_c = L | R;
      OP_XOR:   res_c = L ^ R;
      OP_LOADI: res_c = R;
      OP_SHL: begin
        res_c = shl_w[WIDTH-1:0];
        c_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_c = shr_w[WIDTH:1];
        c_c   = shr_w[0];
      end
      default:  err_c = 1'b1;
    endcase
    flags_c = err_c ? 4'b0000 : {res_c == '0, res_c[WIDTH-1], c_c, v_c};
  end

  always_comb begin
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign O         = o_q;
  assign flags     = flags_q;
  assign err       = err_q;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge ck or negedge res_n) begin
    if (!res_n) begin
      state   <= IDLE;
      o_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (accept) begin
      if (OP == OP_MUL) begin
        state  <= BUSY;
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, L};
        mplier <= R;
        cnt    <= CW'(WIDTH);
      end else begin
        state   <= DONE;
        o_q     <= res_c;
        flags_q <= flags_c;
        err_q   <= err_c;
      end
    end else if (state == BUSY) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state   <= DONE;
        o_q     <= acc_nxt[WIDTH-1:0];
        flags_q <= {acc_nxt[WIDTH-1:0] == '0, acc_nxt[WIDTH-1],
                    |acc_nxt[2*WIDTH-1:WIDTH], 1'b0};
        err_q   <= 1'b0;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
`else
  always_ff @(posedge ck or negedge res_n) begin
    if (!res_n) begin
      state   <= IDLE;
      o_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      state   <= DONE;
      o_q     <= res_c;
      flags_q <= flags_c;
      err_q   <= err_c;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
`endif

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, data path width in bits; legal range 8..32.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from R[SHW-1:0].
REQ-003 ck  input  1  clock; all state changes on rising edge.
REQ-004 res_n  input  1  reset; asynchronous and active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 OP  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LOADI, 6 SHL, 7 SHR, 8 MUL; others illegal.
REQ-008 L, R  input  WIDTH each  left and right operands.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 O  output  WIDTH  result.
REQ-012 flags  output  4  {Z,N,C,V} for the result on O.
REQ-013 err  output  1  result came from an illegal or disabled opcode.

Function
REQ-014 A request is accepted when in_valid and in_ready are both 1 on a rising edge; OP, L and R are captured at that edge.
REQ-015 FSM states are IDLE, BUSY and DONE; reset state is IDLE.
REQ-016 in_ready is 1 in IDLE, is (out_ready) in DONE, and is 0 in BUSY.
REQ-017 For a non-MUL accept, the FSM goes to DONE on the next edge; latency is 1 cycle from accept to out_valid.
REQ-018 For a MUL accept, the FSM goes to BUSY; shift-add runs exactly WIDTH cycles, then DONE; latency is WIDTH+1 cycles.
REQ-019 out_valid is 1 only in DONE; O, flags and err stay stable while out_valid is 1 and out_ready is 0.
REQ-020 In DONE with out_ready=1, the FSM returns to IDLE, or directly to DONE/BUSY if a new request is accepted on the same edge, giving back-to-back throughput.
REQ-021 ADD/SUB produce modulo 2^WIDTH results.
REQ-022 For ADD/SUB, C is carry-out for ADD and borrow (L<R unsigned) for SUB; V is two's-complement overflow.
REQ-023 AND/OR/XOR/LOADI (O=R) force C=0 and V=0.
REQ-024 SHL/SHR are logical shifts of L by R[SHW-1:0]; C is the last bit shifted out, C=0 for amount 0; V=0.
REQ-025 MUL is unsigned; O is the low WIDTH bits of the product; C=1 if the high WIDTH bits are nonzero; V=0.
REQ-026 Z=(O==0) and N=O[WIDTH-1] for all legal opcodes.
REQ-027 An illegal opcode completes with 1-cycle latency and gives O=0, flags=0 and err=1; err=0 otherwise.
REQ-028 Operand changes while BUSY or DONE have no effect on the result.

Reset
REQ-029 res_n=0 immediately forces state IDLE, out_valid=0, O=0, flags=0, err=0 and clears the MUL accumulator and counter.
REQ-030 Reset asserted mid-MUL or in DONE discards the operation; no result is ever presented for it.
REQ-031 After res_n deasserts, in_ready=1 in the first cycle.

Configuration
REQ-032 Macro ALU_MUL_EN controls the multiplier.
REQ-033 With ALU_MUL_EN defined, the MUL datapath and BUSY state are compiled in and behave per REQ-018/025.
REQ-034 Without ALU_MUL_EN, there is no multiplier logic; OP=8 is treated as illegal per REQ-027, and BUSY is unreachable.

Verification (WIDTH=16)
REQ-035 ADD L=0xFFFF R=0x0001 -> one cycle later out_valid=1, O=0x0000, Z=1 N=0 C=1 V=0.
REQ-036 SUB L=0x8000 R=0x0001 -> O=0x7FFF, Z=0 N=0 C=0 V=1; SUB L=0x0001 R=0x0002 -> O=0xFFFF, C=1 N=1.
REQ-037 MUL L=0x0100 R=0x0100 with ALU_MUL_EN -> in_ready=0 for 16 cycles, out_valid on cycle 17, O=0x0000 Z=1 C=1; L=0x0012 R=0x0034 -> O=0x03A8 C=0.
REQ-038 Backpressure: ADD accepted, out_ready=0 for 5 cycles -> O/flags constant, in_ready=0; out_ready=1 with new in_valid -> next result presented on the following cycle.
REQ-039 res_n pulsed low on MUL cycle 8 -> out_valid=0 and O=0 immediately; in_ready=1 after release; no stale result.
REQ-040 OP=0xF -> O=0, flags=0, err=1; without ALU_MUL_EN, OP=8 -> err=1 with 1-cycle latency.
